pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register with a valid/ready handshake and an optional 2-entry skid buffer.
- Generalises the fixed-field stage registers (ID/EX, EX/MEM, MEM/WB) into one block. Payload and exception code are opaque buses.
- Keeps the global cu_stall/cu_flush control and adds back-pressure, bubble tracking and occupancy reporting.
- Instantiated between any two core pipeline stages.

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, global stall/flush,
// optional 2-entry skid buffer so in_ready never depends on out_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cu_stall,
    input  logic              cu_flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_excode,
    input  logic              in_delayslot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_excode,
    output logic              out_delayslot,
    output logic              out_nop,
    output logic [1:0]        occupancy
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [EXC_W-1:0]  r_m_exc;
    logic              r_m_ds;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic [EXC_W-1:0]  r_s_exc;
    logic              r_s_ds;

    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_data;
    logic [EXC_W-1:0]  w_m_exc;
    logic              w_m_ds;
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_data;
    logic [EXC_W-1:0]  w_s_exc;
    logic              w_s_ds;

    logic w_flush;
    logic w_out_fire;
    logic w_in_fire;
    logic w_has_skid;

    assign w_has_skid = (SKID != 0);
    // A flush that lands on a stalled cycle is dropped; control re-issues it.
    assign w_flush    = cu_flush & ~cu_stall;
    assign w_out_fire = r_m_valid & out_ready & ~cu_stall;
    assign w_in_fire  = in_valid & in_ready;

    assign in_ready = resetn & ~cu_stall &
                      (w_has_skid ? ~r_s_valid : (~r_m_valid | out_ready));

    always_comb begin
        w_m_valid = r_m_valid;
        w_m_data  = r_m_data;
        w_m_exc   = r_m_exc;
        w_m_ds    = r_m_ds;
        w_s_valid = r_s_valid;
        w_s_data  = r_s_data;
        w_s_exc   = r_s_exc;
        w_s_ds    = r_s_ds;
        if (w_flush) begin
            w_m_valid = 1'b0;
            w_m_data  = '0;
            w_m_exc   = '0;
            w_m_ds    = 1'b0;
            w_s_valid = 1'b0;
            w_s_data  = '0;
            w_s_exc   = '0;
            w_s_ds    = 1'b0;
        end else if (!cu_stall) begin
            if (w_has_skid && r_m_valid && !w_out_fire) begin
                if (w_in_fire) begin
                    w_s_valid = 1'b1;
                    w_s_data  = in_data;
                    w_s_exc   = in_excode;
                    w_s_ds    = in_delayslot;
                end
            end else if (w_has_skid && w_out_fire && r_s_valid) begin
                w_m_valid = 1'b1;
                w_m_data  = r_s_data;
                w_m_exc   = r_s_exc;
                w_m_ds    = r_s_ds;
                w_s_valid = 1'b0;
                w_s_data  = '0;
                w_s_exc   = '0;
                w_s_ds    = 1'b0;
            end else if (w_in_fire) begin
                w_m_valid = 1'b1;
                w_m_data  = in_data;
                w_m_exc   = in_excode;
                w_m_ds    = in_delayslot;
            end else if (w_out_fire) begin
                w_m_valid = 1'b0;
                w_m_data  = '0;
                w_m_exc   = '0;
                w_m_ds    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_exc   <= '0;
            r_m_ds    <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_exc   <= '0;
            r_s_ds    <= 1'b0;
        end else begin
            r_m_valid <= w_m_valid;
            r_m_data  <= w_m_data;
            r_m_exc   <= w_m_exc;
            r_m_ds    <= w_m_ds;
            r_s_valid <= w_s_valid;
            r_s_data  <= w_s_data;
            r_s_exc   <= w_s_exc;
            r_s_ds    <= w_s_ds;
        end
    end

    assign out_valid     = r_m_valid;
    assign out_data      = r_m_data;
    assign out_excode    = r_m_exc;
    assign out_delayslot = r_m_ds;
    assign out_nop       = ~r_m_valid;
    assign occupancy     = {1'b0, r_m_valid} + {1'b0, r_s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances against a FIFO model,
// a directed vector table, an SKID=0 replace sequence and random traffic.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, iv, ds, ordy;
    logic [31:0] d, e;

    logic        ir1, ov1, ds1, nop1;
    logic [31:0] d1, e1;
    logic [1:0]  occ1;
    logic        ir0, ov0, ds0, nop0;
    logic [31:0] d0, e0;
    logic [1:0]  occ0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .EXC_W(32), .SKID(1)) u1 (
        .clk(clk), .resetn(rst_n), .cu_stall(stall), .cu_flush(flush),
        .in_valid(iv), .in_ready(ir1), .in_data(d), .in_excode(e),
        .in_delayslot(ds), .out_valid(ov1), .out_ready(ordy),
        .out_data(d1), .out_excode(e1), .out_delayslot(ds1),
        .out_nop(nop1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .EXC_W(32), .SKID(0)) u0 (
        .clk(clk), .resetn(rst_n), .cu_stall(stall), .cu_flush(flush),
        .in_valid(iv), .in_ready(ir0), .in_data(d), .in_excode(e),
        .in_delayslot(ds), .out_valid(ov0), .out_ready(ordy),
        .out_data(d0), .out_excode(e0), .out_delayslot(ds0),
        .out_nop(nop0), .occupancy(occ0)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic        ds;
    } ent_t;

    // Reference: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0)
    ent_t q[2][$];

    typedef struct {
        logic        rst_n, stall, flush, iv;
        logic [31:0] d, e;
        logic        ds, ordy;
        logic        x_ir, x_ov;
        logic [31:0] x_d, x_e;
        logic        x_ds;
        logic [1:0]  x_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic r, logic s, logic f, logic v, logic [31:0] dd, logic [31:0] ee,
        logic dds, logic o, logic xir, logic xov, logic [31:0] xd,
        logic [31:0] xe, logic xds, logic [1:0] xocc);
        vec_t t;
        t.rst_n = r; t.stall = s; t.flush = f; t.iv = v;
        t.d = dd; t.e = ee; t.ds = dds; t.ordy = o;
        t.x_ir = xir; t.x_ov = xov; t.x_d = xd; t.x_e = xe;
        t.x_ds = xds; t.x_occ = xocc;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    task automatic model_dut(input int k, input logic a_ir, input logic a_ov,
                             input logic a_nop, input logic [31:0] a_d,
                             input logic [31:0] a_e, input logic a_ds,
                             input logic [1:0] a_occ);
        int   n;
        logic x_ir, ofire, ifire;
        ent_t hd, nw;
        string p;
        n = q[k].size();
        p = $sformatf("u%0d", k);
        x_ir = rst_n && !stall && ((k == 1) ? (n < 2) : (n == 0 || ordy));
        hd.d = 0; hd.e = 0; hd.ds = 0;
        if (n > 0) hd = q[k][0];
        chk({p, ".in_ready"}, a_ir, x_ir);
        chk({p, ".out_valid"}, a_ov, n > 0);
        chk({p, ".out_nop"}, a_nop, n == 0);
        chk({p, ".out_data"}, a_d, hd.d);
        chk({p, ".out_excode"}, a_e, hd.e);
        chk({p, ".out_delayslot"}, a_ds, hd.ds);
        chk({p, ".occupancy"}, a_occ, n);
        ofire = (n > 0) && ordy && !stall;
        ifire = iv && x_ir;
        nw.d = d; nw.e = e; nw.ds = ds;
        if (!rst_n || (flush && !stall)) begin
            q[k].delete();
        end else if (!stall) begin
            if (ofire) void'(q[k].pop_front());
            if (ifire) q[k].push_back(nw);
        end
    endtask

    task automatic tick();
        model_dut(1, ir1, ov1, nop1, d1, e1, ds1, occ1);
        model_dut(0, ir0, ov0, nop0, d0, e0, ds0, occ0);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic s, logic f, logic v, logic [31:0] dd,
                         logic [31:0] ee, logic dds, logic o);
        rst_n = r; stall = s; flush = f; iv = v;
        d = dd; e = ee; ds = dds; ordy = o;
    endtask

    initial begin
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        @(posedge clk);
        #1;

        tbl.push_back(mk(0,0,0,1,32'hDEAD_BEEF,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,0,0,1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,2,0,0,1, 1,1,1,0,0,1));
        tbl.push_back(mk(1,0,0,1,3,0,0,1, 1,1,2,0,0,1));
        tbl.push_back(mk(1,0,0,1,4,0,0,1, 1,1,3,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,1, 1,1,4,0,0,1));
        tbl.push_back(mk(1,0,0,1,32'hA,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,32'hB,0,0,0, 1,1,32'hA,0,0,1));
        tbl.push_back(mk(1,0,0,1,32'hC,0,0,0, 0,1,32'hA,0,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,1,32'hA,0,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,1, 1,1,32'hB,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,32'hA,32'h10,1,0, 1,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,1,1,1,32'h77,0,0,1, 0,1,32'hA,32'h10,1,1));
        tbl.push_back(mk(1,0,1,1,32'h55,0,0,1, 1,1,32'hA,32'h10,1,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,32'h21,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,32'h22,0,0,1, 0,1,32'h21,0,0,1));
        tbl.push_back(mk(1,1,0,1,32'h22,0,0,1, 0,1,32'h21,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,1, 1,1,32'h21,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].iv,
                  tbl[i].d, tbl[i].e, tbl[i].ds, tbl[i].ordy);
            #2;
            chk($sformatf("vec%0d.in_ready", i), ir1, tbl[i].x_ir);
            chk($sformatf("vec%0d.out_valid", i), ov1, tbl[i].x_ov);
            chk($sformatf("vec%0d.out_data", i), d1, tbl[i].x_d);
            chk($sformatf("vec%0d.out_excode", i), e1, tbl[i].x_e);
            chk($sformatf("vec%0d.out_delayslot", i), ds1, tbl[i].x_ds);
            chk($sformatf("vec%0d.occupancy", i), occ1, tbl[i].x_occ);
            tick();
        end

        // SKID=0: full head blocks input until out_ready, then is replaced
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2; tick();
        drive(1, 0, 0, 1, 32'h31, 0, 0, 0);
        #2; tick();
        drive(1, 0, 0, 1, 32'h32, 0, 0, 0);
        #2;
        chk("s0.full.in_ready", ir0, 1'b0);
        chk("s0.full.occupancy", occ0, 2'd1);
        tick();
        drive(1, 0, 0, 1, 32'h33, 0, 0, 1);
        #2;
        chk("s0.swap.in_ready", ir0, 1'b1);
        chk("s0.swap.out_data", d0, 32'h31);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("s0.after.out_data", d0, 32'h33);
        chk("s0.after.occupancy", occ0, 2'd1);
        tick();

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  $urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            #2;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
